ex_muldiv_seq: RTL

//  Multi-cycle RV32M multiply/divide sequencer beside the EX-stage ALU. Replaces the single-cycle combinational MUL/MULH path.

---
 rtl/ex_muldiv_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer that sits beside the EX-stage ALU.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, with signs fixed up at the end.
module ex_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      id_ex_funct3,
    input  logic [XLEN-1:0] id_ex_rega,
    input  logic [XLEN-1:0] id_ex_regb,
    input  logic            flush,
    output logic            muldiv_stall,
    output logic            muldiv_done,
    output logic [XLEN-1:0] muldiv_result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        f3_q;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b, orig_a;
    logic [2*XLEN-1:0] acc;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_next, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;
    logic              div_zero, div_ovf;

    // Operand signedness by funct3: MULH both, MULHSU rs1 only, DIV/REM both.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (id_ex_funct3)
            3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                 a_signed = 1'b1;
            default: ;
        endcase
        a_neg    = a_signed & id_ex_rega[XLEN-1];
        b_neg    = b_signed & id_ex_regb[XLEN-1];
        mag_a_in = a_neg ? -id_ex_rega : id_ex_rega;
        mag_b_in = b_neg ? -id_ex_regb : id_ex_regb;
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, mag_b};
        if (f3_q[2]) begin
            if (div_diff[XLEN])
                acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

    always_comb begin
        div_zero = (mag_b == '0);
        div_ovf  = sign_a & sign_b & (mag_b == XLEN'(1)) & (orig_a == MIN_NEG);
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quot_fix = ((sign_a ^ sign_b) & ~div_zero) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (div_zero) begin
            quot_fix = '1;
            rem_fix  = orig_a;
        end else if (div_ovf) begin
            quot_fix = orig_a;
            rem_fix  = '0;
        end
        case (f3_q)
            3'b000:         fix_result = prod_fix[XLEN-1:0];
            3'b100, 3'b101: fix_result = quot_fix;
            3'b110, 3'b111: fix_result = rem_fix;
            default:        fix_result = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            f3_q          <= '0;
            sign_a        <= 1'b0;
            sign_b        <= 1'b0;
            mag_a         <= '0;
            mag_b         <= '0;
            orig_a        <= '0;
            acc           <= '0;
            muldiv_done   <= 1'b0;
            muldiv_result <= '0;
        end else if (flush) begin
            state       <= IDLE;
            cnt         <= '0;
            muldiv_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    f3_q   <= id_ex_funct3;
                    sign_a <= a_neg;
                    sign_b <= b_neg;
                    mag_a  <= mag_a_in;
                    mag_b  <= mag_b_in;
                    orig_a <= id_ex_rega;
                    acc    <= {{XLEN{1'b0}}, id_ex_funct3[2] ? mag_a_in : mag_b_in};
                    cnt    <= '0;
                    state  <= CALC;
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= FIX;
                end
                FIX: begin
                    muldiv_result <= fix_result;
                    muldiv_done   <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    muldiv_done <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign muldiv_stall = ((state == IDLE) & start) | (state == CALC) | (state == FIX);

endmodule
